// File: rtl/line_steer_ctrl.sv
// Line-follower steering controller: synchronises and debounces three sensor
// rows and drives a graded 4-bit steering code with a change strobe.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | disabled, dir_code held at STOP
// TRACK      | code stable, watching for a sensor or direction change
// DEBOUNCE   | changed pattern must hold DEBOUNCE_CYC cycles
// DECIDE     | latch direction, classify the lead row
// INTERSECT  | lead row empty, steering from the mid row until exit/timeout
`timescale 1ns/1ps
module line_steer_ctrl #(
  parameter int SENS_W        = 2,
  parameter int DEBOUNCE_CYC  = 12_500_000,
  parameter int INTERSECT_CYC = 50_000_000,
  parameter int SYNC_STAGES   = 3,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SENS_W-1:0] front,
  input  logic [SENS_W-1:0] mid,
  input  logic [SENS_W-1:0] rear,
  input  logic              direction,
  input  logic              enable,
  output logic [3:0]        dir_code,
  output logic              dir_valid,
  output logic              lost,
  output logic [2:0]        state_o
);

  localparam int HALF  = SENS_W / 2;
  localparam int ROW_W = 3 * SENS_W;
  localparam int DCW   = $clog2(DEBOUNCE_CYC) + 1;
  localparam int ICW   = $clog2(INTERSECT_CYC) + 1;
  localparam int PCW   = $clog2(SENS_W) + 1;

  localparam logic [3:0] C_PROCEED  = 4'b0000;
  localparam logic [3:0] C_VEER_L   = 4'b0101;
  localparam logic [3:0] C_HARD_L   = 4'b0110;
  localparam logic [3:0] C_NINETY_L = 4'b0111;
  localparam logic [3:0] C_VEER_R   = 4'b1001;
  localparam logic [3:0] C_HARD_R   = 4'b1010;
  localparam logic [3:0] C_NINETY_R = 4'b1011;
  localparam logic [3:0] C_STOP     = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRACK     = 3'd1,
    ST_DEBOUNCE  = 3'd2,
    ST_DECIDE    = 3'd3,
    ST_INTERSECT = 3'd4
  } state_t;

  state_t                             state, state_n;
  logic [DCW-1:0]                     cnt, cnt_n;
  logic [ICW-1:0]                     icnt, icnt_n;
  logic [ROW_W-1:0]                   snap, snap_n;
  logic [ROW_W-1:0]                   stable, stable_n;
  logic                               dir_lat, dir_lat_n;
  logic [3:0]                         code_n;
  logic                               lost_n;
  logic [SYNC_STAGES-1:0][ROW_W-1:0]  sync_q;
  logic [ROW_W-1:0]                   s_cur;
  logic [SENS_W-1:0]                  s_front, s_mid, s_rear;
  logic [SENS_W-1:0]                  lead, mid_m;
  logic                               dir_use;
  logic                               mid_lo, mid_hi;

  function automatic logic [SENS_W-1:0] bit_rev(input logic [SENS_W-1:0] v);
    logic [SENS_W-1:0] r;
    for (int i = 0; i < SENS_W; i++) r[i] = v[SENS_W-1-i];
    return r;
  endfunction

  function automatic logic [PCW-1:0] pop_half(input logic [HALF-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < HALF; i++) n = n + PCW'(v[i]);
    return n;
  endfunction

  // Lower half is the left side; more hits on the right half steers left.
  function automatic logic [3:0] classify(input logic [SENS_W-1:0] row);
    logic [PCW-1:0] nl, nr;
    logic [3:0]     c;
    nl = pop_half(row[HALF-1:0]);
    nr = pop_half(row[SENS_W-1:HALF]);
    c  = C_PROCEED;
    if (&row)         c = C_PROCEED;
    else if (nl < nr) c = (nr - nl == PCW'(1)) ? C_VEER_L : C_HARD_L;
    else if (nl > nr) c = (nl - nr == PCW'(1)) ? C_VEER_R : C_HARD_R;
    return c;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], {rear, mid, front}};
  end

  assign s_cur   = (ACTIVE_LOW != 0) ? ~sync_q[SYNC_STAGES-1] : sync_q[SYNC_STAGES-1];
  assign s_front = s_cur[SENS_W-1:0];
  assign s_mid   = s_cur[2*SENS_W-1:SENS_W];
  assign s_rear  = s_cur[3*SENS_W-1:2*SENS_W];

  // DECIDE classifies with the direction it is about to latch.
  assign dir_use = (state == ST_DECIDE) ? direction : dir_lat;
  assign lead    = dir_use ? s_front : bit_rev(s_rear);
  assign mid_m   = dir_use ? s_mid : bit_rev(s_mid);
  assign mid_lo  = |mid_m[HALF-1:0];
  assign mid_hi  = |mid_m[SENS_W-1:HALF];

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    icnt_n    = icnt;
    snap_n    = snap;
    stable_n  = stable;
    dir_lat_n = dir_lat;
    code_n    = dir_code;
    lost_n    = lost;
    if (!enable) begin
      state_n   = ST_IDLE;
      code_n    = C_STOP;
      lost_n    = 1'b0;
      cnt_n     = '0;
      icnt_n    = '0;
      snap_n    = '0;
      stable_n  = '0;
      dir_lat_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: state_n = ST_TRACK;
        ST_TRACK: begin
          if (s_cur != snap || direction != dir_lat) begin
            state_n = ST_DEBOUNCE;
            snap_n  = s_cur;
            cnt_n   = '0;
          end
        end
        ST_DEBOUNCE: begin
          if (s_cur == stable && direction == dir_lat) begin
            state_n = ST_TRACK;
            snap_n  = stable;
          end else if (s_cur != snap) begin
            snap_n = s_cur;
            cnt_n  = '0;
          end else if (cnt == DCW'(DEBOUNCE_CYC - 1)) begin
            state_n = ST_DECIDE;
          end else begin
            cnt_n = cnt + DCW'(1);
          end
        end
        ST_DECIDE: begin
          dir_lat_n = direction;
          snap_n    = s_cur;
          stable_n  = s_cur;
          if (|lead) begin
            code_n  = classify(lead);
            state_n = ST_TRACK;
          end else begin
            code_n  = C_PROCEED;
            icnt_n  = '0;
            state_n = ST_INTERSECT;
          end
        end
        ST_INTERSECT: begin
          icnt_n = icnt + ICW'(1);
          if (&mid_m) begin
            code_n   = C_STOP;
            state_n  = ST_TRACK;
            snap_n   = s_cur;
            stable_n = s_cur;
          end else if (icnt == ICW'(INTERSECT_CYC - 1)) begin
            code_n   = C_STOP;
            lost_n   = 1'b1;
            state_n  = ST_TRACK;
            snap_n   = s_cur;
            stable_n = s_cur;
          end else if (direction != dir_lat) begin
            state_n = ST_DEBOUNCE;
            snap_n  = s_cur;
            cnt_n   = '0;
          end else if (|lead) begin
            state_n = ST_DECIDE;
          end else if (mid_lo && !mid_hi) begin
            code_n = C_NINETY_L;
          end else if (mid_hi && !mid_lo) begin
            code_n = C_NINETY_R;
          end else if (dir_code != C_NINETY_L && dir_code != C_NINETY_R) begin
            code_n = C_PROCEED;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      icnt      <= '0;
      snap      <= '0;
      stable    <= '0;
      dir_lat   <= 1'b0;
      dir_code  <= C_STOP;
      dir_valid <= 1'b0;
      lost      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      icnt      <= icnt_n;
      snap      <= snap_n;
      stable    <= stable_n;
      dir_lat   <= dir_lat_n;
      dir_code  <= code_n;
      dir_valid <= (code_n != dir_code);
      lost      <= lost_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_line_steer_ctrl.sv
// Bench for line_steer_ctrl: directed and random sensor episodes, expected
// steering events queued from a rule-level model and checked by a monitor.
`timescale 1ns/1ps
module tb_line_steer_ctrl;

  localparam int W    = 4;
  localparam int DEB  = 4;
  localparam int ICYC = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + DEB + 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [W-1:0] front, mid, rear;
  logic       direction, enable;
  logic [3:0] dir_code;
  logic       dir_valid, lost;
  logic [2:0] state_o;

  line_steer_ctrl #(
    .SENS_W(W), .DEBOUNCE_CYC(DEB), .INTERSECT_CYC(ICYC),
    .SYNC_STAGES(SYNC), .ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .front(front), .mid(mid), .rear(rear),
    .direction(direction), .enable(enable), .dir_code(dir_code),
    .dir_valid(dir_valid), .lost(lost), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] code;
    logic       lost;
    int         at;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  logic [3:0] m_code;
  logic       m_lost;

  function automatic logic [3:0] lead_of(logic [3:0] f, logic [3:0] r, logic d);
    return d ? f : {r[0], r[1], r[2], r[3]};
  endfunction

  // Steering rule: compare line hits on the left (bits 1:0) and right (bits 3:2).
  function automatic logic [3:0] model_code(logic [3:0] lead);
    int l, r;
    l = $countones(lead[1:0]);
    r = $countones(lead[3:2]);
    if (lead == 4'b1111) return 4'b0000;
    if (l < r) return (r - l == 1) ? 4'b0101 : 4'b0110;
    if (l > r) return (l - r == 1) ? 4'b1001 : 4'b1010;
    return 4'b0000;
  endfunction

  always @(negedge clk) begin
    if (!rst && dir_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event got code=%b lost=%b at cycle %0d", dir_code, lost, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (dir_code !== e.code || lost !== e.lost) begin
          failures++;
          $display("FAIL event got code=%b lost=%b want code=%b lost=%b", dir_code, lost, e.code, e.lost);
        end
        if (e.at >= 0) begin
          checks++;
          if (cyc != e.at) begin
            failures++;
            $display("FAIL latency got cycle %0d want cycle %0d", cyc, e.at);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input logic [3:0] c, input int at);
    exp_t e;
    if (c != m_code) begin
      e.code = c;
      e.lost = m_lost;
      e.at   = at;
      q.push_back(e);
      m_code = c;
    end
  endtask

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending events want 0", q.size());
      q.delete();
    end
  endtask

  task automatic apply(input logic [3:0] f, input logic [3:0] m, input logic [3:0] r, input logic d);
    front = f; mid = m; rear = r; direction = d;
  endtask

  initial begin
    logic [3:0] f, m, r, g;
    logic       d;
    int         k;

    rst = 1'b1; enable = 1'b0;
    apply(4'b1111, 4'b0000, 4'b0000, 1'b1);
    m_code = 4'b1111; m_lost = 1'b0;
    tick(3);
    check("reset_code", dir_code, 4'b1111);
    check("reset_valid", {3'b0, dir_valid}, 4'b0000);
    check("reset_lost", {3'b0, lost}, 4'b0000);
    check("reset_state", {1'b0, state_o}, 4'd0);

    rst = 1'b0; enable = 1'b1;
    tick(1);
    check("idle_to_track", {1'b0, state_o}, 4'd1);
    expect_ev(4'b0000, -1);
    tick(14);
    drain(10);

    // HARD_L with exact pin-to-code latency
    k = cyc;
    apply(4'b1100, 4'b0000, 4'b0000, 1'b1);
    expect_ev(model_code(4'b1100), k + LAT);
    tick(14);
    drain(10);

    apply(4'b1111, 4'b0000, 4'b0000, 1'b1);
    expect_ev(4'b0000, -1);
    tick(14);
    drain(10);

    apply(4'b0111, 4'b0000, 4'b0000, 1'b1);
    tick(2);
    apply(4'b1111, 4'b0000, 4'b0000, 1'b1);
    tick(10);
    check("glitch_back_to_track", {1'b0, state_o}, 4'd1);
    check("glitch_code_held", dir_code, 4'b0000);

    for (int ep = 0; ep < 60; ep++) begin
      if ($urandom_range(0, 2) == 0) begin
        g = 4'($urandom);
        front = g;
        tick($urandom_range(1, DEB - 1));
        front = f;
        if (ep == 0) front = 4'b1111;
        tick(8);
      end
      do begin
        f = 4'($urandom); m = 4'($urandom); r = 4'($urandom);
        d = 1'($urandom_range(0, 1));
      end while (lead_of(f, r, d) == 4'b0000);
      apply(f, m, r, d);
      expect_ev(model_code(lead_of(f, r, d)), -1);
      tick($urandom_range(12, 20));
      drain(6);
    end

    // Intersection steered by mid row, then leaving it
    apply(4'b1100, 4'b0000, 4'b0000, 1'b1);
    expect_ev(4'b0110, -1);
    tick(14);
    drain(10);
    k = cyc;
    apply(4'b0000, 4'b0001, 4'b0000, 1'b1);
    expect_ev(4'b0000, k + LAT);
    expect_ev(4'b0111, k + LAT + 1);
    tick(10);
    check("intersect_state", {1'b0, state_o}, 4'd4);
    tick(4);
    apply(4'b1111, 4'b0001, 4'b0000, 1'b1);
    expect_ev(4'b0000, -1);
    tick(10);
    drain(10);
    check("exit_to_track", {1'b0, state_o}, 4'd1);

    // Intersection timeout
    apply(4'b1100, 4'b0000, 4'b0000, 1'b1);
    expect_ev(4'b0110, -1);
    tick(14);
    drain(10);
    k = cyc;
    apply(4'b0000, 4'b0000, 4'b0000, 1'b1);
    expect_ev(4'b0000, k + LAT);
    m_lost = 1'b1;
    expect_ev(4'b1111, k + LAT + ICYC);
    tick(30);
    drain(10);
    check("lost_set", {3'b0, lost}, 4'b0001);
    check("timeout_track", {1'b0, state_o}, 4'd1);
    enable = 1'b0;
    m_lost = 1'b0;
    tick(1);
    check("lost_cleared", {3'b0, lost}, 4'b0000);
    check("disable_idle", {1'b0, state_o}, 4'd0);

    // Backward travel uses the mirrored rear row
    enable = 1'b1;
    apply(4'b0101, 4'b0000, 4'b1000, 1'b0);
    expect_ev(model_code(lead_of(4'b0101, 4'b1000, 1'b0)), -1);
    tick(14);
    drain(10);
    check("bwd_veer_r", dir_code, 4'b1001);

    apply(4'b1100, 4'b0000, 4'b0000, 1'b0);
    expect_ev(4'b0000, -1);
    tick(10);
    check("bwd_intersect", {1'b0, state_o}, 4'd4);
    direction = 1'b1;
    tick(1);
    check("flip_to_debounce", {1'b0, state_o}, 4'd2);
    expect_ev(model_code(4'b1100), -1);
    tick(10);
    drain(10);

    // Asynchronous reset while debouncing
    apply(4'b0011, 4'b0000, 4'b0000, 1'b1);
    tick(4);
    check("pre_reset_debounce", {1'b0, state_o}, 4'd2);
    #2 rst = 1'b1;
    #1;
    check("midrst_code", dir_code, 4'b1111);
    check("midrst_state", {1'b0, state_o}, 4'd0);
    check("midrst_valid", {3'b0, dir_valid}, 4'b0000);
    m_code = 4'b1111; m_lost = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("post_rst_track", {1'b0, state_o}, 4'd1);
    expect_ev(model_code(4'b0011), -1);
    tick(14);
    drain(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
